// File: rtl/store_trace_pkg.sv
// rtl/store_trace_pkg.sv - shared types and helpers for the store trace monitor
package store_trace_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DONE    = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_e;

    function automatic int entry_width(input int win_words, input int data_w);
        return $clog2(win_words) + data_w;
    endfunction

    // Limit is formed at 64 bits so a window ending at the top of the address space cannot wrap.
    function automatic logic in_window(input logic [63:0] adr,
                                       input logic [63:0] base,
                                       input logic [63:0] words);
        return (adr >= base) && (adr < base + (words << 2));
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered read port and exact occupancy
module sync_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       rd_valid_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             pop_ok, push_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a concurrent push.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = pop_ok;
        if (push_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop_ok) begin
            rptr_d    = rptr_q + 1'b1;
            rd_data_d = mem_q[rptr_q];
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= push_data_i;
        end
    end

    assign count_o    = count_q;
    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/store_trace_monitor.sv
// rtl/store_trace_monitor.sv - snoops core stores, traces result-window writes, flags end/timeout
module store_trace_monitor
    import store_trace_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 16,
    parameter logic [ADDR_W-1:0] WIN_BASE  = 32'h0000_00A0,
    parameter int                WIN_WORDS = 20,
    parameter logic [ADDR_W-1:0] DONE_ADDR = 32'h0000_0FFC,
    parameter int                TIMEOUT   = 400
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         MemWrite,
    input  logic [ADDR_W-1:0]            DataAdr,
    input  logic [DATA_W-1:0]            WriteData,
    input  logic                         rd_en,
    output logic [DATA_W-1:0]            rd_data,
    output logic [$clog2(WIN_WORDS)-1:0] rd_idx,
    output logic                         rd_valid,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         overflow,
    output logic                         misaligned,
    output logic                         done,
    output logic                         timed_out
);

    localparam int IDX_W   = $clog2(WIN_WORDS);
    localparam int ENTRY_W = entry_width(WIN_WORDS, DATA_W);
    localparam int TMR_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_e           state_q, state_d;
    logic [TMR_W-1:0] cyc_q, cyc_d;
    logic             overflow_q, overflow_d;
    logic             misaligned_q, misaligned_d;

    logic             running;
    logic             sentinel;
    logic             win_hit;
    logic             aligned;
    logic             push_req;
    logic             timeout_hit;
    logic [IDX_W-1:0] store_idx;
    logic             fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] fifo_rd_entry;

    assign running   = (state_q == ST_RUN);
    assign sentinel  = MemWrite && (DataAdr == DONE_ADDR);
    assign win_hit   = in_window(64'(DataAdr), 64'(WIN_BASE), 64'(WIN_WORDS));
    assign aligned   = (DataAdr[1:0] == 2'b00);
    assign store_idx = IDX_W'((DataAdr - WIN_BASE) >> 2);

    // The sentinel is a control marker, never trace data, even if it lands inside the window.
    assign push_req    = running && MemWrite && win_hit && aligned && !sentinel;
    assign timeout_hit = (TIMEOUT != 0) && (cyc_q == TMR_W'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (sentinel) begin
                    state_d = ST_DONE;
                end else if (timeout_hit) begin
                    state_d = ST_TIMEOUT;
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        cyc_d        = cyc_q;
        overflow_d   = overflow_q;
        misaligned_d = misaligned_q;
        if (running && (cyc_q != '1)) begin
            cyc_d = cyc_q + 1'b1;
        end
        if (push_req && fifo_full && !(rd_en && !fifo_empty)) begin
            overflow_d = 1'b1;
        end
        if (running && MemWrite && win_hit && !aligned && !sentinel) begin
            misaligned_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            cyc_q        <= '0;
            overflow_q   <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            overflow_q   <= overflow_d;
            misaligned_q <= misaligned_d;
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push_req),
        .push_data_i ({store_idx, WriteData}),
        .pop_i       (rd_en),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (count),
        .rd_data_o   (fifo_rd_entry),
        .rd_valid_o  (rd_valid)
    );

    assign {rd_idx, rd_data} = fifo_rd_entry;
    assign overflow   = overflow_q;
    assign misaligned = misaligned_q;
    assign done       = (state_q == ST_DONE);
    assign timed_out  = (state_q == ST_TIMEOUT);

endmodule

// File: tb/tb_store_trace_monitor.sv
// tb/tb_store_trace_monitor.sv - directed self-checking bench for store_trace_monitor
module tb_store_trace_monitor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;
    logic        rd_en = 1'b0;
    logic [31:0] rd_data;
    logic [4:0]  rd_idx;
    logic        rd_valid;
    logic [4:0]  count;
    logic        overflow, misaligned, done, timed_out;

    int checks = 0;
    int errors = 0;

    store_trace_monitor dut (
        .clk        (clk),
        .reset      (reset),
        .MemWrite   (MemWrite),
        .DataAdr    (DataAdr),
        .WriteData  (WriteData),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_idx     (rd_idx),
        .rd_valid   (rd_valid),
        .count      (count),
        .overflow   (overflow),
        .misaligned (misaligned),
        .done       (done),
        .timed_out  (timed_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; MemWrite = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        MemWrite = 1'b1; DataAdr = a; WriteData = d;
        @(negedge clk);
        MemWrite = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({count, rd_valid, overflow, misaligned, done, timed_out, rd_data, rd_idx} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got count=%0d valid=%b ovf=%b mis=%b done=%b to=%b data=%h idx=%0d exp all 0",
                     count, rd_valid, overflow, misaligned, done, timed_out, rd_data, rd_idx);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        store(32'hA0, 32'd7);
        store(32'hA4, 32'd9);
        store(32'hEC, 32'd42);
        checks++;
        if (count !== 5'd3 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_pre_done got count=%0d done=%b exp count=3 done=0", count, done);
        end
        store(32'hFFC, 32'd1);
        checks++;
        if (done !== 1'b1 || count !== 5'd3) begin
            errors++;
            $display("FAIL basic_done got done=%b count=%0d exp done=1 count=3", done, count);
        end
        pop();
        checks++;
        if (rd_valid !== 1'b1 || rd_idx !== 5'd0 || rd_data !== 32'd7 || count !== 5'd2) begin
            errors++;
            $display("FAIL basic_pop0 got v=%b idx=%0d data=%0d count=%0d exp v=1 idx=0 data=7 count=2",
                     rd_valid, rd_idx, rd_data, count);
        end
        pop();
        checks++;
        if (rd_valid !== 1'b1 || rd_idx !== 5'd1 || rd_data !== 32'd9 || count !== 5'd1) begin
            errors++;
            $display("FAIL basic_pop1 got v=%b idx=%0d data=%0d count=%0d exp v=1 idx=1 data=9 count=1",
                     rd_valid, rd_idx, rd_data, count);
        end
        pop();
        checks++;
        if (rd_valid !== 1'b1 || rd_idx !== 5'd19 || rd_data !== 32'd42 || count !== 5'd0) begin
            errors++;
            $display("FAIL basic_pop2 got v=%b idx=%0d data=%0d count=%0d exp v=1 idx=19 data=42 count=0",
                     rd_valid, rd_idx, rd_data, count);
        end
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 32'd42 || rd_idx !== 5'd19) begin
            errors++;
            $display("FAIL basic_hold got v=%b idx=%0d data=%0d exp v=0 idx=19 data=42", rd_valid, rd_idx, rd_data);
        end
        checks++;
        if (overflow !== 1'b0 || misaligned !== 1'b0 || timed_out !== 1'b0) begin
            errors++;
            $display("FAIL basic_flags got ovf=%b mis=%b to=%b exp 0 0 0", overflow, misaligned, timed_out);
        end
    endtask

    task automatic test_window_edges();
        do_reset();
        store(32'h9C, 32'd1);
        store(32'hF0, 32'd2);
        store(32'hEC, 32'd5);
        checks++;
        if (count !== 5'd1) begin
            errors++;
            $display("FAIL edges_count got %0d exp 1", count);
        end
        pop();
        checks++;
        if (rd_valid !== 1'b1 || rd_idx !== 5'd19 || rd_data !== 32'd5) begin
            errors++;
            $display("FAIL edges_entry got v=%b idx=%0d data=%0d exp v=1 idx=19 data=5", rd_valid, rd_idx, rd_data);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 18; i++) begin
            store(32'hA0 + 32'(4 * i), 32'(100 + i));
        end
        checks++;
        if (count !== 5'd16 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_state got count=%0d ovf=%b exp count=16 ovf=1", count, overflow);
        end
        for (int i = 0; i < 16; i++) begin
            pop();
            checks++;
            if (rd_valid !== 1'b1 || rd_idx !== 5'(i) || rd_data !== 32'(100 + i)) begin
                errors++;
                $display("FAIL ovf_entry%0d got v=%b idx=%0d data=%0d exp v=1 idx=%0d data=%0d",
                         i, rd_valid, rd_idx, rd_data, i, 100 + i);
            end
        end
        checks++;
        if (count !== 5'd0) begin
            errors++;
            $display("FAIL ovf_drained got count=%0d exp 0", count);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            store(32'hA0 + 32'(4 * i), 32'(200 + i));
        end
        @(negedge clk);
        MemWrite = 1'b1; DataAdr = 32'hE8; WriteData = 32'd999; rd_en = 1'b1;
        @(negedge clk);
        MemWrite = 1'b0; rd_en = 1'b0;
        checks++;
        if (count !== 5'd16 || overflow !== 1'b0 || rd_valid !== 1'b1 || rd_idx !== 5'd0 || rd_data !== 32'd200) begin
            errors++;
            $display("FAIL b2b_full got count=%0d ovf=%b v=%b idx=%0d data=%0d exp count=16 ovf=0 v=1 idx=0 data=200",
                     count, overflow, rd_valid, rd_idx, rd_data);
        end
        do_reset();
        @(negedge clk);
        MemWrite = 1'b1; DataAdr = 32'hA0; WriteData = 32'd5; rd_en = 1'b1;
        @(negedge clk);
        MemWrite = 1'b0; rd_en = 1'b0;
        checks++;
        if (count !== 5'd1 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_empty got count=%0d v=%b exp count=1 v=0", count, rd_valid);
        end
    endtask

    task automatic test_misaligned();
        do_reset();
        store(32'hA0, 32'd1);
        store(32'hA2, 32'd2);
        checks++;
        if (misaligned !== 1'b1 || count !== 5'd1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL misaligned got mis=%b count=%0d ovf=%b exp mis=1 count=1 ovf=0", misaligned, count, overflow);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        repeat (399) @(negedge clk);
        checks++;
        if (timed_out !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early got %b exp 0 at cycle 399", timed_out);
        end
        @(negedge clk);
        checks++;
        if (timed_out !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL timeout_hit got to=%b done=%b exp to=1 done=0 at cycle 400", timed_out, done);
        end
        store(32'hA0, 32'd3);
        store(32'hFFC, 32'd0);
        checks++;
        if (count !== 5'd0 || done !== 1'b0 || timed_out !== 1'b1) begin
            errors++;
            $display("FAIL timeout_frozen got count=%0d done=%b to=%b exp count=0 done=0 to=1", count, done, timed_out);
        end
        pop();
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pop_empty got v=%b exp 0", rd_valid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            store(32'hB0 + 32'(4 * i), 32'(i));
        end
        store(32'hFFC, 32'd1);
        checks++;
        if (count !== 5'd5 || done !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre got count=%0d done=%b exp count=5 done=1", count, done);
        end
        do_reset();
        checks++;
        if (count !== 5'd0 || done !== 1'b0 || timed_out !== 1'b0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_post got count=%0d done=%b to=%b v=%b exp all 0", count, done, timed_out, rd_valid);
        end
        store(32'hA8, 32'd77);
        checks++;
        if (count !== 5'd1) begin
            errors++;
            $display("FAIL rstmid_capture got count=%0d exp 1", count);
        end
        pop();
        checks++;
        if (rd_valid !== 1'b1 || rd_idx !== 5'd2 || rd_data !== 32'd77) begin
            errors++;
            $display("FAIL rstmid_entry got v=%b idx=%0d data=%0d exp v=1 idx=2 data=77", rd_valid, rd_idx, rd_data);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_window_edges();
        test_overflow();
        test_back_to_back();
        test_misaligned();
        test_reset_mid();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
